// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-source round-robin packet arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  // IDLE arbitrates; BUSY passes the granted source through until its last beat.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_ymux4to1.sv
// Plain 4:1 data multiplexer. The arbiter owns the select.
module yMux4to1 #(
  parameter int SIZE = 32
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c
);

  // Route the selected source to the output.
  always_comb begin
    case (c)
      2'd0:    z = a0;
      2'd1:    z = a1;
      2'd2:    z = a2;
      default: z = a3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one output channel between four packet sources.
// A grant is held from the first beat until the granted source's last beat,
// then one IDLE cycle re-arbitrates starting after the last-served source.
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high. The granted source sees out_ready directly as its in_ready, and
// the consumer sees the granted source's in_valid/in_last directly. Sources
// hold data and last stable while valid is high and ready is low.
//
// busy mirrors the FSM state (1 = ST_BUSY) so checkers can observe it.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     in_valid,
  input  logic [NUM_SRC-1:0]     in_last,
  output logic [NUM_SRC-1:0]     in_ready,
  input  logic [SIZE-1:0]        a0,
  input  logic [SIZE-1:0]        a1,
  input  logic [SIZE-1:0]        a2,
  input  logic [SIZE-1:0]        a3,
  output logic [SIZE-1:0]        z,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  // First requester scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); the last
  // served source is checked last so it gets lowest priority.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // State, grant and priority pointer; reset abandons any grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and handshake routing.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|in_valid) begin
          sel_d   = rr_pick(in_valid, ptr_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        out_valid       = in_valid[sel_q];
        out_last        = in_last[sel_q];
        in_ready[sel_q] = out_ready;
        if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q == ST_BUSY);

  yMux4to1 #(.SIZE(SIZE)) u_mux (
    .z  (z),
    .a0 (a0),
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .c  (sel_q)
  );

endmodule
